// File: rtl/parser_input_arbiter_if.sv
// Beat-level handshake bundle between N sources, the arbiter and the parser input.
// The master side drives source beats and parser readiness; the slave side is the
// arbiter, which returns per-source ready and produces the merged parser stream.
interface parser_input_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC*32-1:0] in_data;
  logic [N_SRC-1:0]    in_val;
  logic [N_SRC-1:0]    in_last;
  logic [N_SRC-1:0]    in_ready;
  logic [31:0]         out_data;
  logic                out_val;
  logic                out_last;
  logic                out_ready;

  modport master (
    output in_data, in_val, in_last, out_ready,
    input  in_ready, out_data, out_val, out_last
  );

  modport slave (
    input  in_data, in_val, in_last, out_ready,
    output in_ready, out_data, out_val, out_last
  );
endinterface

// File: rtl/parser_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the single 32-bit parser input.
// A granted source owns the parser until its last beat; packets longer than
// MAX_BEATS are cut at MAX_BEATS (forced last) and the remainder is drained.
module parser_input_arbiter #(
  parameter  int N_SRC     = 4,
  parameter  int MAX_BEATS = 16,
  localparam int GW        = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   reset_b,
  parser_input_arbiter_if.slave  bus,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   trunc_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          trunc_err_q, trunc_err_d;

  logic [N_SRC-1:0] grant_oh;
  logic [31:0]      sel_data;
  logic             sel_val;
  logic             sel_last;
  logic [GW-1:0]    pick_idx;
  logic [GW-1:0]    next_ptr;
  logic             at_max;

  logic [N_SRC-1:0] in_ready_c;
  logic [31:0]      out_data_c;
  logic             out_val_c;
  logic             out_last_c;

  // Select the granted source's beat and form its one-hot mask.
  always_comb begin
    grant_oh = '0;
    sel_data = '0;
    sel_val  = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == GW'(i)) begin
        grant_oh[i] = 1'b1;
        sel_data    = bus.in_data[32*i +: 32];
        sel_val     = bus.in_val[i];
        sel_last    = bus.in_last[i];
      end
    end
  end

  // Round-robin search: first requester at rr_ptr, rr_ptr+1, ... wrapping at N_SRC.
  always_comb begin
    logic found;
    found    = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!found && bus.in_val[i] && (((int'(rr_ptr_q) + k) % N_SRC) == i)) begin
          found    = 1'b1;
          pick_idx = GW'(i);
        end
      end
    end
  end

  // Pointer for the next arbitration: the source after the one just served.
  always_comb begin
    next_ptr = (grant_q == GW'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
    at_max   = (beat_cnt_q == CW'(MAX_BEATS - 1));
  end

  // Next-state and handshake logic for IDLE (arbitrate), BUSY (pass through), DRAIN (discard).
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    trunc_err_d = 1'b0;
    in_ready_c  = '0;
    out_data_c  = '0;
    out_val_c   = 1'b0;
    out_last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.in_val) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        out_data_c = sel_data;
        out_val_c  = sel_val;
        out_last_c = sel_last | at_max;
        in_ready_c = bus.out_ready ? grant_oh : '0;
        if (sel_val && bus.out_ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else if (at_max) begin
            state_d     = DRAIN;
            trunc_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        in_ready_c = grant_oh;
        if (sel_val && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.out_data = out_data_c;
  assign bus.out_val  = out_val_c;
  assign bus.out_last = out_last_c;
  assign grant_id     = grant_q;
  assign busy         = (state_q != IDLE);
  assign trunc_err    = trunc_err_q;

endmodule

// File: tb/tb_parser_input_arbiter.sv
// Directed bench for parser_input_arbiter: small per-source packet generators,
// a log of beats seen at the parser side, and hand-computed expectations.
module tb_parser_input_arbiter;
  localparam int N_SRC     = 4;
  localparam int MAX_BEATS = 16;

  logic       clk = 1'b0;
  logic       reset_b;
  logic [1:0] grant_id;
  logic       busy;
  logic       trunc_err;

  parser_input_arbiter_if #(.N_SRC(N_SRC)) bus ();

  parser_input_arbiter #(.N_SRC(N_SRC), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit s_on[N_SRC];
  bit s_gap[N_SRC];
  int s_len[N_SRC];
  int s_beat[N_SRC];
  int s_rep[N_SRC];
  int s_stream[N_SRC];
  int s_seq[N_SRC];
  int s_lenb[N_SRC];

  logic [31:0] obs_data[$];
  logic        obs_last[$];
  logic [1:0]  obs_gnt[$];
  int          obs_cyc[$];
  int          trunc_cnt;
  int          trunc_cyc;
  int          drain_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] beat_word(input int s, input int b);
    int lb, st, sq;
    lb = s_lenb[s];
    st = s_stream[s];
    sq = s_seq[s];
    if (b == 0) return {lb[7:0], lb[15:8], st[7:0], st[15:8]};
    if (b == 1) return {sq[7:0], sq[15:8], sq[23:16], sq[31:24]};
    return 32'hD000_0000 | 32'(s << 8) | 32'(b);
  endfunction

  function automatic bit any_on();
    bit r;
    r = 1'b0;
    for (int i = 0; i < N_SRC; i++) r |= s_on[i];
    return r;
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < N_SRC; i++) begin
      bus.in_val[i]           = s_on[i] && !s_gap[i];
      bus.in_last[i]          = (s_beat[i] == s_len[i] - 1);
      bus.in_data[32*i +: 32] = beat_word(i, s_beat[i]);
    end
  endtask

  task automatic start_pkt(input int s, input int nb, input int stream, input int seq,
                           input int lenb, input int rep);
    s_on[s]     = 1'b1;
    s_gap[s]    = 1'b0;
    s_len[s]    = nb;
    s_beat[s]   = 0;
    s_rep[s]    = rep;
    s_stream[s] = stream;
    s_seq[s]    = seq;
    s_lenb[s]   = lenb;
  endtask

  task automatic clear_log();
    obs_data.delete();
    obs_last.delete();
    obs_gnt.delete();
    obs_cyc.delete();
    trunc_cnt = 0;
    trunc_cyc = -1;
    drain_cnt = 0;
  endtask

  // One clock: sample at the falling edge, then advance sources on accepted beats.
  task automatic tick();
    logic [N_SRC-1:0] acc;
    #4;
    acc = bus.in_val & bus.in_ready;
    if (bus.out_val === 1'b1 && bus.out_ready === 1'b1) begin
      obs_data.push_back(bus.out_data);
      obs_last.push_back(bus.out_last);
      obs_gnt.push_back(grant_id);
      obs_cyc.push_back(cyc);
    end
    if (trunc_err === 1'b1) begin
      trunc_cnt++;
      trunc_cyc = cyc;
    end
    if (acc !== '0 && bus.out_val === 1'b0) drain_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_SRC; i++) begin
      if (acc[i] === 1'b1) begin
        if (s_beat[i] == s_len[i] - 1) begin
          if (s_rep[i] > 0) begin
            s_rep[i]--;
            s_beat[i] = 0;
            s_seq[i]++;
          end else begin
            s_on[i] = 1'b0;
          end
        end else begin
          s_beat[i]++;
        end
      end
    end
    applyStimulus();
  endtask

  task automatic run_until_done(input int max_cyc, input string tag);
    int k;
    k = 0;
    while ((any_on() || busy) && k < max_cyc) begin
      tick();
      k++;
    end
    checkOutput({tag, "_timeout"}, 32'(any_on() || busy), 32'd0);
  endtask

  // Directed sequence covering reset, streaming, fairness, truncation, stalls and mid-packet reset.
  initial begin
    reset_b       = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N_SRC; i++) start_pkt(i, 3, i, 0, 12, 0);
    applyStimulus();
    clear_log();

    $display("[TB] reset with all sources requesting");
    for (int k = 0; k < 5; k++) tick();
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_val", 32'(bus.out_val), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_trunc", 32'(trunc_err), 32'd0);
    for (int i = 0; i < N_SRC; i++) s_on[i] = 1'b0;
    reset_b = 1'b1;
    applyStimulus();
    tick();
    clear_log();

    $display("[TB] two back-to-back 5-beat packets from src0");
    start_pkt(0, 5, 12, 1, 20, 1);
    applyStimulus();
    run_until_done(40, "t2");
    checkOutput("t2_count", 32'(obs_data.size()), 32'd10);
    checkOutput("t2_word0", obs_data[0], 32'h1400_0C00);
    checkOutput("t2_word1", obs_data[1], 32'h0100_0000);
    checkOutput("t2_pay2", obs_data[2], 32'hD000_0002);
    checkOutput("t2_pay4", obs_data[4], 32'hD000_0004);
    checkOutput("t2_last4", 32'(obs_last[4]), 32'd1);
    checkOutput("t2_last3", 32'(obs_last[3]), 32'd0);
    checkOutput("t2_seq2", obs_data[6], 32'h0200_0000);
    checkOutput("t2_back2back", 32'(obs_cyc[1] - obs_cyc[0]), 32'd1);
    checkOutput("t2_bubble", 32'(obs_cyc[5] - obs_cyc[4]), 32'd2);
    checkOutput("t2_grant", 32'(obs_gnt[9]), 32'd0);

    $display("[TB] all four sources requesting continuously");
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    for (int i = 0; i < N_SRC; i++) start_pkt(i, 3, 10 + i, 1, 12, 1);
    applyStimulus();
    clear_log();
    run_until_done(60, "t3");
    checkOutput("t3_count", 32'(obs_data.size()), 32'd24);
    for (int k = 0; k < 24 && k < obs_data.size(); k++) begin
      checkOutput($sformatf("t3_grant%0d", k), 32'(obs_gnt[k]), 32'((k / 3) % 4));
      checkOutput($sformatf("t3_last%0d", k), 32'(obs_last[k]), 32'((k % 3) == 2));
      if ((k % 3) == 1)
        checkOutput($sformatf("t3_seq%0d", k), obs_data[k], (k < 12) ? 32'h0100_0000 : 32'h0200_0000);
      if ((k % 3) == 2)
        checkOutput($sformatf("t3_pay%0d", k), obs_data[k], 32'hD000_0002 | 32'(((k / 3) % 4) << 8));
    end

    $display("[TB] overlong 20-beat packet from src1");
    clear_log();
    start_pkt(1, 20, 1, 7, 80, 0);
    applyStimulus();
    run_until_done(60, "t4");
    checkOutput("t4_count", 32'(obs_data.size()), 32'd16);
    checkOutput("t4_word0", obs_data[0], 32'h5000_0100);
    checkOutput("t4_last15", 32'(obs_last[14]), 32'd0);
    checkOutput("t4_last16", 32'(obs_last[15]), 32'd1);
    checkOutput("t4_pay16", obs_data[15], 32'hD000_010F);
    checkOutput("t4_grant", 32'(obs_gnt[15]), 32'd1);
    checkOutput("t4_trunc_cnt", 32'(trunc_cnt), 32'd1);
    checkOutput("t4_trunc_time", 32'(trunc_cyc - obs_cyc[15]), 32'd1);
    checkOutput("t4_drained", 32'(drain_cnt), 32'd4);
    clear_log();
    start_pkt(0, 1, 0, 0, 4, 0);
    start_pkt(2, 1, 2, 0, 4, 0);
    applyStimulus();
    run_until_done(20, "t4b");
    checkOutput("t4_rr_first", 32'(obs_gnt[0]), 32'd2);
    checkOutput("t4_rr_second", 32'(obs_gnt[1]), 32'd0);
    checkOutput("t4_single_last", 32'(obs_last[0]), 32'd1);
    checkOutput("t4_single_word", obs_data[0], 32'h0400_0200);
    clear_log();
    start_pkt(3, 16, 3, 0, 64, 0);
    applyStimulus();
    run_until_done(40, "t4c");
    checkOutput("t4_exact_count", 32'(obs_data.size()), 32'd16);
    checkOutput("t4_exact_last", 32'(obs_last[15]), 32'd1);
    checkOutput("t4_exact_nolast", 32'(obs_last[14]), 32'd0);
    checkOutput("t4_exact_trunc", 32'(trunc_cnt), 32'd0);
    checkOutput("t4_exact_drain", 32'(drain_cnt), 32'd0);

    $display("[TB] parser stalls and source gap");
    clear_log();
    start_pkt(0, 4, 5, 3, 16, 0);
    applyStimulus();
    tick();
    tick();
    bus.out_ready = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    s_gap[0] = 1'b1;
    start_pkt(2, 1, 2, 0, 4, 0);
    bus.out_ready = 1'b1;
    applyStimulus();
    for (int k = 0; k < 3; k++) tick();
    checkOutput("t5_gap_grant", 32'(grant_id), 32'd0);
    checkOutput("t5_gap_busy", 32'(busy), 32'd1);
    checkOutput("t5_gap_count", 32'(obs_data.size()), 32'd2);
    s_gap[0] = 1'b0;
    applyStimulus();
    run_until_done(30, "t5");
    checkOutput("t5_count", 32'(obs_data.size()), 32'd5);
    checkOutput("t5_word0", obs_data[0], 32'h1000_0500);
    checkOutput("t5_word1", obs_data[1], 32'h0300_0000);
    checkOutput("t5_pay2", obs_data[2], 32'hD000_0002);
    checkOutput("t5_pay3", obs_data[3], 32'hD000_0003);
    checkOutput("t5_last3", 32'(obs_last[3]), 32'd1);
    checkOutput("t5_src2_grant", 32'(obs_gnt[4]), 32'd2);
    checkOutput("t5_src2_word", obs_data[4], 32'h0400_0200);

    $display("[TB] reset in the middle of a packet");
    start_pkt(0, 6, 6, 9, 24, 0);
    applyStimulus();
    tick();
    tick();
    tick();
    reset_b = 1'b0;
    tick();
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_out_val", 32'(bus.out_val), 32'd0);
    checkOutput("t6_grant", 32'(grant_id), 32'd0);
    checkOutput("t6_in_ready", 32'(bus.in_ready), 32'd0);
    s_on[0] = 1'b0;
    reset_b = 1'b1;
    start_pkt(1, 2, 1, 1, 8, 0);
    start_pkt(3, 4, 3, 5, 16, 0);
    applyStimulus();
    clear_log();
    run_until_done(30, "t6");
    checkOutput("t6_count", 32'(obs_data.size()), 32'd6);
    checkOutput("t6_first_grant", 32'(obs_gnt[0]), 32'd1);
    checkOutput("t6_src1_seq", obs_data[1], 32'h0100_0000);
    checkOutput("t6_src1_last", 32'(obs_last[1]), 32'd1);
    checkOutput("t6_src3_grant", 32'(obs_gnt[2]), 32'd3);
    checkOutput("t6_src3_word0", obs_data[2], 32'h1000_0300);
    checkOutput("t6_src3_word1", obs_data[3], 32'h0500_0000);
    checkOutput("t6_src3_pay", obs_data[5], 32'hD000_0303);
    checkOutput("t6_src3_last", 32'(obs_last[5]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
